add3_selftest: RTL and testbench
================================

Name: add3_selftest

Overview:
- Operand driver and result checker for the `full_add3` adder, i.e. the opposite end of its a/b -> r interface.
- On `start`, drives every (a, b) pair onto the adder inputs and waits a programmable settle time.
- Compares the returned `r` against an internal golden sum, then reports an error count, pass/fail and the first failing vector.
- Sits beside the adder as an on-chip BIST engine, replacing hand-written stimulus.

Parameters:
- WIDTH, 3: operand width; adder result width is WIDTH+1.
- SETTLE, 2: wait cycles between operand update and result sampling; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a sweep; accepted only in IDLE or DONE.
- a_out  output  WIDTH  operand a to adder, registered.
- b_out  output  WIDTH  operand b to adder, registered.
- r_in  input  WIDTH+1  adder result.
- busy  output  1  high from the cycle after an accepted start until DONE.
- done  output  1  level; high in DONE until next accepted start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching vectors.
- fail_a  output  WIDTH  a of first mismatch.
- fail_b  output  WIDTH  b of first mismatch.
- fail_r  output  WIDTH+1  r_in captured at first mismatch.

Behaviour:
- Reset: one clock (`clk`); reset is asynchronous, active-low (`rst_n`). While `rst_n`=0 all outputs and internal registers are 0 and state=IDLE, taking effect immediately without waiting for a clock edge. Reset mid-sweep aborts with no residue.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- Internal index `idx` is 2*WIDTH bits; a_out=idx[2W-1:W], b_out=idx[W-1:0]; settle counter `cnt`.
- IDLE/DONE + start=1 -> APPLY. On this transition: idx=0, err_count=0, fail_* cleared, done=0, busy=1.
- APPLY (1 cycle): a_out/b_out updated from idx; cnt=SETTLE. Next state is WAIT, or CHECK if SETTLE==0.
- WAIT: cnt decrements each cycle; moves to CHECK when cnt reaches 1, so WAIT lasts exactly SETTLE cycles.
- CHECK (1 cycle):
  - expected = zero-extended a_out + zero-extended b_out, computed at WIDTH+1 bits; no overflow is possible.
  - Mismatch with r_in: err_count+1; if this is the first error, fail_a/fail_b/fail_r are captured.
  - idx == all ones -> DONE (busy=0, done=1); else idx+1 -> APPLY.
- Latency: SETTLE+2 cycles per vector. Full sweep takes 2^(2*WIDTH)*(SETTLE+2) cycles from accepted start to done rising. Defaults: 64*4=256 cycles.
- err_count cannot exceed 2^(2*WIDTH), so it is sized to hold that value with no saturation logic.
- start while busy: ignored, no state change.
- start in the same cycle DONE is entered: ignored; it must arrive while in DONE.
- a_out/b_out hold the last vector in DONE until the next start.
- r_in is sampled only in CHECK; its value in other states is don't-care.

Optional Feature:
- Macro: ADD3_SELFTEST_STOP_ON_FAIL_EN.
- Defined: CHECK with a mismatch goes directly to DONE (done=1, busy=0, pass=0, err_count=1); a_out/b_out hold the failing vector.
- Undefined: the sweep always completes all vectors and counts every mismatch.

Test Plan:
- Correct full_add3 model, defaults; pulse start -> done rises 256 cycles later, pass=1, err_count=0, fail_a=fail_b=fail_r=0.
- Adder model with r[0] stuck at 0 -> err_count=32, pass=0, fail_a=0, fail_b=1, fail_r=4'b0000.
- Adder model with r[3] forced to 0 (carry dropped) -> err_count=28, fail_a=1, fail_b=7, fail_r=4'b0000.
- rst_n low asynchronously mid-sweep (cycle 100) -> all outputs 0 without a clock edge; after release, a new start completes a clean 256-cycle sweep with pass=1.
- Start re-pulsed at cycles 10 and 50 during the sweep -> ignored, done still at cycle 256. SETTLE=0 with the correct model -> done after 128 cycles, pass=1.
- ADD3_SELFTEST_STOP_ON_FAIL_EN defined, r[0]-stuck model -> done after second vector, err_count=1, a_out=0, b_out=1, pass=0.

Source files
------------

// File: rtl/add3_selftest.sv
// add3_selftest: BIST engine for a WIDTH-bit adder with a WIDTH+1-bit result.
// It sweeps every (a, b) operand pair, waits SETTLE cycles for the adder to
// settle, and then compares r_in with an internally computed sum. It reports
// the error count, pass/fail, and the first failing vector.
// Optional build macro: ADD3_SELFTEST_STOP_ON_FAIL_EN. When it is defined,
// the sweep ends at the first mismatch.
module add3_selftest #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH:0]       r_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [WIDTH:0]       fail_r
);

    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg;
    logic [CW-1:0]   cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [EW-1:0]   err_reg;
    logic [WIDTH-1:0] fail_a_reg, fail_b_reg;
    logic [WIDTH:0]  fail_r_reg;

    logic [WIDTH:0]  expected;
    logic            mismatch;
    logic            idx_last;
    logic            accept;

    // The golden sum is taken from the registered operands currently on the adder.
    assign expected = {1'b0, a_reg} + {1'b0, b_reg};
    assign mismatch = (r_in != expected);
    assign idx_last = (idx_reg == {IW{1'b1}});
    // A start pulse is honoured only when no sweep is in progress.
    assign accept   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                state_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef ADD3_SELFTEST_STOP_ON_FAIL_EN
                if (idx_last || mismatch) begin
`else
                if (idx_last) begin
`endif
                    state_next = S_DONE;
                end else begin
                    state_next = S_APPLY;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: the sweep index, the operands, the settle counter and the error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg    <= '0;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            err_reg    <= '0;
            fail_a_reg <= '0;
            fail_b_reg <= '0;
            fail_r_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        idx_reg    <= '0;
                        err_reg    <= '0;
                        fail_a_reg <= '0;
                        fail_b_reg <= '0;
                        fail_r_reg <= '0;
                    end
                end
                S_APPLY: begin
                    a_reg   <= idx_reg[IW-1:WIDTH];
                    b_reg   <= idx_reg[WIDTH-1:0];
                    cnt_reg <= CW'(SETTLE);
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_reg <= err_reg + EW'(1);
                        if (err_reg == '0) begin
                            fail_a_reg <= a_reg;
                            fail_b_reg <= b_reg;
                            fail_r_reg <= r_in;
                        end
                    end
                    if (!idx_last) begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy = (state_reg == S_APPLY) || (state_reg == S_WAIT) || (state_reg == S_CHECK);
        done = (state_reg == S_DONE);
        pass = done && (err_reg == '0);
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign err_count = err_reg;
    assign fail_a    = fail_a_reg;
    assign fail_b    = fail_b_reg;
    assign fail_r    = fail_r_reg;

endmodule

// File: tb/tb_add3_selftest.sv
// Testbench for add3_selftest. The adder model in this bench can inject faults.
// Expected sweep results go into a scoreboard queue when a sweep starts.
// They are popped and compared once done rises.
module tb_add3_selftest;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;          // 0: SETTLE=2 instance, 1: SETTLE=0 instance
    int   fault_mode;   // 0 correct, 1 r[0] stuck at 0, 2 r[3] forced to 0

    always #5 clk = ~clk;

    // Signals for the SETTLE=2 instance
    logic       start2, busy2, done2, pass2;
    logic [2:0] a2, b2, fa2, fb2;
    logic [3:0] r2, fr2;
    logic [6:0] err2;
    // Signals for the SETTLE=0 instance
    logic       start0, busy0, done0, pass0;
    logic [2:0] a0, b0, fa0, fb0;
    logic [3:0] r0, fr0;
    logic [6:0] err0;

    function automatic logic [3:0] adder_model(input logic [2:0] a, input logic [2:0] b, input int mode);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (mode == 1) s[0] = 1'b0;
        if (mode == 2) s[3] = 1'b0;
        return s;
    endfunction

    assign start2 = sel ? 1'b0 : start;
    assign start0 = sel ? start : 1'b0;
    always_comb r2 = adder_model(a2, b2, fault_mode);
    always_comb r0 = adder_model(a0, b0, 0);

    add3_selftest #(.WIDTH(3), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2), .r_in(r2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_a(fa2), .fail_b(fb2), .fail_r(fr2)
    );

    add3_selftest #(.WIDTH(3), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0), .r_in(r0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_a(fa0), .fail_b(fb0), .fail_r(fr0)
    );

    // Observed view of whichever instance is selected
    logic       cur_busy, cur_done, cur_pass;
    logic [2:0] cur_a, cur_b, cur_fa, cur_fb;
    logic [3:0] cur_fr;
    logic [6:0] cur_err;
    always_comb begin
        cur_busy = sel ? busy0 : busy2;
        cur_done = sel ? done0 : done2;
        cur_pass = sel ? pass0 : pass2;
        cur_a    = sel ? a0    : a2;
        cur_b    = sel ? b0    : b2;
        cur_fa   = sel ? fa0   : fa2;
        cur_fb   = sel ? fb0   : fb2;
        cur_fr   = sel ? fr0   : fr2;
        cur_err  = sel ? err0  : err2;
    end

    typedef struct {
        int cycles;
        int err;
        int pass;
        int fa;
        int fb;
        int fr;
        int a_last;
        int b_last;
    } sweep_exp_t;

    sweep_exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference outcome of one sweep for the given settle time and fault mode
    function automatic sweep_exp_t model_sweep(input int settle, input int mode);
        sweep_exp_t e;
        logic [2:0] a, b;
        logic [3:0] good, got;
        bit stop;
        e = '{default: 0};
        stop = 1'b0;
        for (int i = 0; i < 64 && !stop; i++) begin
            a = 3'(i >> 3);
            b = 3'(i & 7);
            good = {1'b0, a} + {1'b0, b};
            got  = adder_model(a, b, mode);
            e.cycles = (i + 1) * (settle + 2);
            e.a_last = int'(a);
            e.b_last = int'(b);
            if (got != good) begin
                if (e.err == 0) begin
                    e.fa = int'(a);
                    e.fb = int'(b);
                    e.fr = int'(got);
                end
                e.err++;
`ifdef ADD3_SELFTEST_STOP_ON_FAIL_EN
                stop = 1'b1;
`endif
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input bit sel_i, input int mode, input bit repulse, input string name);
        sweep_exp_t e;
        int n;
        sel = sel_i;
        fault_mode = mode;
        sb_q.push_back(model_sweep(sel_i ? 0 : 2, mode));
        pulse_start();
        check_val({name, "_busy_start"}, int'(cur_busy), 1);
        check_val({name, "_done_start"}, int'(cur_done), 0);
        n = 0;
        while (!cur_done && n < 2000) begin
            start = repulse && (n == 10 || n == 50);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        $display("sweep %s sel=%0d mode=%0d cycles=%0d err=%0d pass=%0d",
                 name, sel_i, mode, n, cur_err, cur_pass);
        check_val({name, "_cycles"}, n, e.cycles);
        check_val({name, "_busy_end"}, int'(cur_busy), 0);
        check_val({name, "_err"}, int'(cur_err), e.err);
        check_val({name, "_pass"}, int'(cur_pass), e.pass);
        check_val({name, "_fail_a"}, int'(cur_fa), e.fa);
        check_val({name, "_fail_b"}, int'(cur_fb), e.fb);
        check_val({name, "_fail_r"}, int'(cur_fr), e.fr);
        check_val({name, "_a_out"}, int'(cur_a), e.a_last);
        check_val({name, "_b_out"}, int'(cur_b), e.b_last);
    endtask

    task automatic check_zero(input string name);
        check_val({name, "_busy"}, int'(busy2), 0);
        check_val({name, "_done"}, int'(done2), 0);
        check_val({name, "_pass"}, int'(pass2), 0);
        check_val({name, "_err"}, int'(err2), 0);
        check_val({name, "_a_out"}, int'(a2), 0);
        check_val({name, "_b_out"}, int'(b2), 0);
        check_val({name, "_fail_a"}, int'(fa2), 0);
        check_val({name, "_fail_b"}, int'(fb2), 0);
        check_val({name, "_fail_r"}, int'(fr2), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel = 1'b0;
        fault_mode = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(1'b0, 0, 1'b0, "clean");
        run_sweep(1'b0, 1, 1'b0, "r0_stuck");
        run_sweep(1'b0, 2, 1'b0, "carry_drop");

        // Assert reset asynchronously in the middle of a sweep.
        sel = 1'b0;
        fault_mode = 0;
        pulse_start();
        repeat (100) @(negedge clk);
        check_val("abort_busy_before", int'(busy2), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(1'b0, 0, 1'b0, "after_rst");

        run_sweep(1'b0, 0, 1'b1, "repulse");
        run_sweep(1'b1, 0, 1'b0, "settle0");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
